priority_code_strober: RTL and testbench
========================================

Name: priority_code_strober

Overview:
- Counterpart to the team's 8-input priority encoder.
- Accepts a stream of 3-bit channel codes, each with an "idle" flag, over a valid/ready handshake, and buffers them in a 2-entry queue.
- Replays each code as a timed one-hot strobe on 8 output lines.
- Sits downstream of the encoder and drives per-channel service/acknowledge lines.

Parameters:
- HOLD_CYCLES, 4: cycles each one-hot strobe stays high; legal range 1..255.
- GAP_CYCLES, 1: extra all-zero cycles inserted after each strobe; legal range 0..255.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  a code is presented.
- in_ready  out  1  queue can accept; equals (count != 2), derived from registers only.
- in_code  in  3  channel index 0..7.
- in_idle  in  1  entry carries "no request" (the encoder's IDLE); in_code is ignored when set.
- out_onehot  out  8  registered one-hot strobe, bit in_code.
- out_active  out  1  high while out_onehot != 0.
- out_done  out  1  one-cycle pulse when a strobe ends.
- idle_pulse  out  1  one-cycle pulse when an idle entry is consumed.
- busy  out  1  FSM not in S_IDLE, or queue not empty.

Behaviour:
- Reset (async, immediate):
  - queue count = 0, read/write pointers = 0, FSM = S_IDLE, counter = 0.
  - out_onehot = 0, out_active = 0, out_done = 0, idle_pulse = 0, busy = 0.
  - in_ready = 1 once rst is low.
- Queue:
  - 2 entries of {idle, code[2:0]}. Push on the edge where in_valid & in_ready.
  - When count == 2, in_ready = 0 and no push occurs, even if a pop happens on the same edge.
  - When count == 1, a push and a pop on the same edge leaves count at 1.
  - Order is strictly FIFO.
- FSM states: S_IDLE, S_HOLD, S_GAP.
  - S_IDLE, queue non-empty: pop the head on this edge.
    - idle = 0: out_onehot <= 1 << code, counter <= HOLD_CYCLES-1, go to S_HOLD.
    - idle = 1: idle_pulse <= 1 for one cycle, out_onehot stays 0, remain in S_IDLE. The next entry may be popped on the following edge.
  - S_IDLE, queue empty: hold all outputs at 0.
  - S_HOLD:
    - counter != 0: decrement.
    - counter == 0: out_onehot <= 0, out_done <= 1 (one cycle).
      - GAP_CYCLES = 0: go to S_IDLE.
      - GAP_CYCLES > 0: counter <= GAP_CYCLES-1, go to S_GAP.
  - S_GAP: decrement; at counter == 0, go to S_IDLE. No pops occur in S_GAP.
- Timing:
  - Latency: entry pushed at edge k (queue empty, FSM in S_IDLE) -> out_onehot valid after edge k+1.
  - out_onehot is high for exactly HOLD_CYCLES cycles.
  - All-zero cycles between back-to-back non-idle strobes = GAP_CYCLES + 1.
  - out_done coincides with the first zero cycle after a strobe.
- Outputs:
  - out_onehot always has at most one bit set.
  - out_active = |out_onehot.
- Counter: 8 bits, unsigned; never wraps below 0, since every transition out of a state happens at 0.
- Reset mid-strobe: outputs drop to 0 asynchronously, no out_done is produced, and the queue contents are discarded.

Test Plan:
- Single entry: HOLD=4, GAP=1, push code=5 idle=0 at edge 0 -> out_onehot = 8'h20 during cycles 1..4, out_done=1 in cycle 5, busy=0 from cycle 7.
- Boundary codes: push code=0 then code=7 back-to-back -> 8'h01 for 4 cycles, 2 zero cycles, then 8'h80 for 4 cycles; two out_done pulses.
- Back-pressure: hold in_valid high with codes 1, 2, 3, 4 from edge 0 -> in_ready=0 when count=2, no entry lost or duplicated, strobes appear in order 8'h02, 8'h04, 8'h08, 8'h10.
- Idle entry: push idle=1, code=6, then code=3 -> idle_pulse for one cycle, out_onehot never 8'h40, then 8'h08 for HOLD_CYCLES cycles.
- Reset mid-operation: assert rst during cycle 2 of a code=4 strobe with one entry queued -> out_onehot=0 immediately, no out_done, count=0, in_ready=1 after release, queued entry never strobes.
- Parameter corners: HOLD=1, GAP=0 with 3 back-to-back entries -> each strobe lasts 1 cycle, separated by exactly 1 zero cycle.

Source files
------------

// File: rtl/priority_code_strober.sv
// priority_code_strober: buffers {idle, code} entries in a 2-deep FIFO and
// replays each non-idle code as a one-hot strobe held for HOLD_CYCLES,
// followed by GAP_CYCLES all-zero cycles.
// Ports:
//   clk, rst               rising-edge clock, async active-high reset
//   in_valid/in_ready      input handshake (in_ready = queue not full)
//   in_code, in_idle       channel index and "no request" flag
//   out_onehot, out_active registered strobe and its OR-reduction
//   out_done               one-cycle pulse on the first zero cycle after a strobe
//   idle_pulse             one-cycle pulse when an idle entry is consumed
//   busy                   engine active or queue non-empty (registered)
module priority_code_strober #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    input  logic       in_idle,
    output logic [7:0] out_onehot,
    output logic       out_active,
    output logic       out_done,
    output logic       idle_pulse,
    output logic       busy
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ENTRY_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    logic [ENTRY_W-1:0] q_mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic               head_idle;
    logic [2:0]         head_code;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [7:0]         onehot_next;
    logic               done_next;
    logic               idle_pulse_next;

    // Ready depends only on the occupancy register, so a pop on the same
    // edge never frees a slot for a push when the queue is full.
    assign in_ready  = (count != 2'd2);
    assign push      = in_valid && in_ready;
    assign head      = q_mem[rd_ptr];
    assign head_idle = head[3];
    assign head_code = head[2:0];

    // Two-entry FIFO storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_mem[0] <= '0;
            q_mem[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                q_mem[wr_ptr] <= {in_idle, in_code};
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // State register plus registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            out_onehot <= '0;
            out_active <= 1'b0;
            out_done   <= 1'b0;
            idle_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            out_onehot <= onehot_next;
            out_active <= |onehot_next;
            out_done   <= done_next;
            idle_pulse <= idle_pulse_next;
            busy       <= (state != S_IDLE) || (count != 2'd0);
        end
    end

    // Next-state and counter; every exit from HOLD/GAP happens at zero
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != 2'd0) begin
                    pop = 1'b1;
                    if (!head_idle) begin
                        state_next = S_HOLD;
                        cnt_next   = CNT_W'(HOLD_CYCLES - 1);
                    end
                end
            end
            S_HOLD: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else if (GAP_CYCLES == 0) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_GAP;
                    cnt_next   = CNT_W'(GAP_CYCLES - 1);
                end
            end
            S_GAP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        onehot_next     = '0;
        done_next       = 1'b0;
        idle_pulse_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != 2'd0) begin
                    if (head_idle) begin
                        idle_pulse_next = 1'b1;
                    end else begin
                        onehot_next = 8'(1) << head_code;
                    end
                end
            end
            S_HOLD: begin
                if (cnt != '0) begin
                    onehot_next = out_onehot;
                end else begin
                    done_next = 1'b1;
                end
            end
            default: begin
                onehot_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_priority_code_strober.sv
// Bench for priority_code_strober: three parameterisations share one input
// stream; each is compared every cycle against a schedule-based model.
module tb_priority_code_strober;

    localparam int NI = 3;
    localparam int NC = 2048;
    localparam int HOLD_T [NI] = '{4, 1, 3};
    localparam int GAP_T  [NI] = '{1, 0, 2};

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_idle;
    logic       rdy  [NI];
    logic [7:0] oh   [NI];
    logic       act  [NI];
    logic       dn   [NI];
    logic       ip   [NI];
    logic       bz   [NI];

    int n_chk;
    int n_err;
    int edge_cnt;

    // Model state: FIFO contents, earliest edge a pop may happen, and
    // per-cycle expected outputs scheduled when an entry is consumed.
    logic [3:0] mq [NI][$];
    int         npop [NI];
    logic [7:0] exp_oh   [NI][NC];
    logic       exp_dn   [NI][NC];
    logic       exp_ip   [NI][NC];
    logic       exp_bz   [NI][NC];
    logic       exp_rdy  [NI][NC];

    priority_code_strober #(.HOLD_CYCLES(HOLD_T[0]), .GAP_CYCLES(GAP_T[0])) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_code(in_code), .in_idle(in_idle), .out_onehot(oh[0]),
        .out_active(act[0]), .out_done(dn[0]), .idle_pulse(ip[0]), .busy(bz[0]));

    priority_code_strober #(.HOLD_CYCLES(HOLD_T[1]), .GAP_CYCLES(GAP_T[1])) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_code(in_code), .in_idle(in_idle), .out_onehot(oh[1]),
        .out_active(act[1]), .out_done(dn[1]), .idle_pulse(ip[1]), .busy(bz[1]));

    priority_code_strober #(.HOLD_CYCLES(HOLD_T[2]), .GAP_CYCLES(GAP_T[2])) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_code(in_code), .in_idle(in_idle), .out_onehot(oh[2]),
        .out_active(act[2]), .out_done(dn[2]), .idle_pulse(ip[2]), .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Forget everything scheduled from cycle c onward
    task automatic model_reset(input int c);
        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            npop[i] = 0;
            for (int k = (c < 0 ? 0 : c); k < NC; k++) begin
                exp_oh[i][k] = '0;
                exp_dn[i][k] = 1'b0;
                exp_ip[i][k] = 1'b0;
                exp_bz[i][k] = 1'b0;
                exp_rdy[i][k] = 1'b1;
            end
        end
    endtask

    // Model update at each rising edge, using the inputs presented before it
    always @(posedge clk) begin
        int e;
        logic [3:0] ent;
        logic can_push;
        e = edge_cnt;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                mq[i].delete();
                npop[i] = 0;
            end else if (e < NC) begin
                exp_bz[i][e] = (e < npop[i]) || (mq[i].size() != 0);
                can_push = in_valid && (mq[i].size() != 2);
                if (e >= npop[i] && mq[i].size() != 0) begin
                    ent = mq[i].pop_front();
                    if (ent[3]) begin
                        exp_ip[i][e] = 1'b1;
                        npop[i] = e + 1;
                    end else begin
                        for (int k = 0; k < HOLD_T[i]; k++)
                            if (e + k < NC) exp_oh[i][e + k] = 8'(1) << ent[2:0];
                        if (e + HOLD_T[i] < NC) exp_dn[i][e + HOLD_T[i]] = 1'b1;
                        npop[i] = e + HOLD_T[i] + GAP_T[i] + 1;
                    end
                end
                if (can_push) mq[i].push_back({in_idle, in_code});
                exp_rdy[i][e] = (mq[i].size() != 2);
            end
        end
        edge_cnt = edge_cnt + 1;
    end

    // Per-cycle comparison on the falling edge
    always @(negedge clk) begin
        int c;
        if (edge_cnt > 0 && !rst && edge_cnt <= NC) begin
            c = edge_cnt - 1;
            for (int i = 0; i < NI; i++) begin
                check($sformatf("onehot%0d@%0d", i, c), 32'(oh[i]), 32'(exp_oh[i][c]));
                check($sformatf("active%0d@%0d", i, c), 32'(act[i]), 32'(exp_oh[i][c] != 8'h00));
                check($sformatf("done%0d@%0d", i, c), 32'(dn[i]), 32'(exp_dn[i][c]));
                check($sformatf("idlep%0d@%0d", i, c), 32'(ip[i]), 32'(exp_ip[i][c]));
                check($sformatf("busy%0d@%0d", i, c), 32'(bz[i]), 32'(exp_bz[i][c]));
                check($sformatf("ready%0d@%0d", i, c), 32'(rdy[i]), 32'(exp_rdy[i][c]));
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] code, input logic idl);
        @(negedge clk);
        #1;
        in_valid = v;
        in_code  = code;
        in_idle  = idl;
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) drive(1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        logic seen_full;
        logic taken;
        n_chk    = 0;
        n_err    = 0;
        edge_cnt = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_code  = 3'd0;
        in_idle  = 1'b0;
        model_reset(0);

        // Reset state while rst is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_onehot%0d", i), 32'(oh[i]), 32'h0);
            check($sformatf("rst_active%0d", i), 32'(act[i]), 32'h0);
            check($sformatf("rst_done%0d", i), 32'(dn[i]), 32'h0);
            check($sformatf("rst_idlep%0d", i), 32'(ip[i]), 32'h0);
            check($sformatf("rst_busy%0d", i), 32'(bz[i]), 32'h0);
        end
        #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++)
            check($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'h1);

        // Single entry, code 5
        drive(1'b1, 3'd5, 1'b0);
        idle_cycles(12);

        // Boundary codes back-to-back
        drive(1'b1, 3'd0, 1'b0);
        drive(1'b1, 3'd7, 1'b0);
        idle_cycles(16);

        // Back-pressure: source advances only on an accepted handshake
        seen_full = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            taken = 1'b0;
            for (int t = 0; t < 50 && !taken; t++) begin
                @(negedge clk);
                #1;
                in_valid = 1'b1;
                in_code  = 3'(k);
                in_idle  = 1'b0;
                taken    = rdy[0];
                if (!rdy[0]) seen_full = 1'b1;
                @(posedge clk);
            end
            check($sformatf("bp_accept%0d", k), 32'(taken), 32'h1);
        end
        check("bp_full_seen", 32'(seen_full), 32'h1);
        idle_cycles(30);

        // Idle entry followed by a real one
        drive(1'b1, 3'd6, 1'b1);
        drive(1'b1, 3'd3, 1'b0);
        idle_cycles(12);

        // Reset in the second cycle of a code-4 strobe with one entry queued
        drive(1'b1, 3'd4, 1'b0);
        drive(1'b1, 3'd2, 1'b0);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_strobe_pre", 32'(oh[0]), 32'h10);
        rst = 1'b1;
        model_reset(edge_cnt - 1);
        #1;
        check("mid_rst_onehot", 32'(oh[0]), 32'h0);
        check("mid_rst_active", 32'(act[0]), 32'h0);
        check("mid_rst_busy", 32'(bz[0]), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(rdy[0]), 32'h1);
        idle_cycles(12);

        // Randomised traffic
        for (int n = 0; n < 400; n++)
            drive($urandom_range(0, 9) < 7, 3'($urandom), $urandom_range(0, 4) == 0);
        idle_cycles(40);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
